// File: rtl/vend_pkg.sv
// vend_pkg: shared state/coin encodings and datapath widths for the vending sequencer
package vend_pkg;
  localparam int CREDIT_W = 4;
  localparam int STOCK_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_VEND, S_PAYOUT} state_t;
  typedef enum logic [1:0] {COIN_NONE = 2'b00, COIN_ONE = 2'b01, COIN_TWO = 2'b10, COIN_INV = 2'b11} coin_t;
  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [CREDIT_W:0] credit_sum_t;
  typedef logic [STOCK_W-1:0] stock_t;
  function automatic credit_sum_t coin_value(input coin_t c);
    return c == COIN_ONE ? credit_sum_t'(1) : c == COIN_TWO ? credit_sum_t'(2) : '0;
  endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: coin, selection, motor and payout signals between the machine front panel and the sequencer
interface vend_if;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       refill;
  logic       motor_done;
  logic       payout_ready;
  logic       motor_req;
  logic [1:0] motor_id;
  logic       payout_valid;
  logic       coin_reject;
  logic       err_nostock;
  logic       err_credit;
  logic       jam;
  logic [3:0] credit;
  logic [3:0] sold_out;
  logic       busy;
  modport slave (
    input  coin, sel_valid, sel_id, cancel, refill, motor_done, payout_ready,
    output motor_req, motor_id, payout_valid, coin_reject, err_nostock, err_credit, jam, credit, sold_out, busy
  );
  modport master (
    output coin, sel_valid, sel_id, cancel, refill, motor_done, payout_ready,
    input  motor_req, motor_id, payout_valid, coin_reject, err_nostock, err_credit, jam, credit, sold_out, busy
  );
endinterface

// File: rtl/vend_stock.sv
// vend_stock: four per-product stock counters with refill load, jam force-zero and sale decrement
module vend_stock
  import vend_pkg::*;
#(
  parameter int STOCK_INIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_dec,
  input  logic       i_zero,
  input  logic [1:0] i_id,
  output logic [3:0] o_sold_out
);
  stock_t r_stock [4];
  // Refill beats jam force-zero, which beats a sale decrement on the addressed product
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int k = 0; k < 4; k++) r_stock[k] <= stock_t'(STOCK_INIT);
    else
      for (int k = 0; k < 4; k++)
        if (i_load) r_stock[k] <= stock_t'(STOCK_INIT);
        else if (i_zero && i_id == 2'(k)) r_stock[k] <= '0;
        else if (i_dec && i_id == 2'(k) && r_stock[k] != '0) r_stock[k] <= r_stock[k] - 1'b1;
  // A product is sold out when its counter is empty
  always_comb
    for (int k = 0; k < 4; k++) o_sold_out[k] = r_stock[k] == '0;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-credit vending controller with dispense handshake, motor timeout and coin payout
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE0        = 3,
  parameter int PRICE1        = 5,
  parameter int PRICE2        = 7,
  parameter int PRICE3        = 9,
  parameter int CREDIT_MAX    = 9,
  parameter int STOCK_INIT    = 8,
  parameter int MOTOR_TIMEOUT = 15
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);
  localparam int CW = $clog2(MOTOR_TIMEOUT + 1);
  state_t      r_state;
  credit_t     r_credit;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_motor_id;
  logic        r_motor_req, r_payout_valid, r_coin_reject, r_err_nostock, r_err_credit, r_jam, r_busy;
  logic [3:0]  w_sold_out;
  credit_sum_t w_coin_val, w_jam_sum;
  credit_t     w_sum, w_sel_price, w_vend_price;
  logic        w_idle, w_sel, w_sel_ok, w_refill, w_accept, w_timeout;
  logic [1:0]  w_stock_id;
  function automatic credit_t price_of(input logic [1:0] id);
    return id == 2'd0 ? credit_t'(PRICE0) : id == 2'd1 ? credit_t'(PRICE1) : id == 2'd2 ? credit_t'(PRICE2) : credit_t'(PRICE3);
  endfunction
  // Decode coin acceptance, selection outcome and motor timeout against the registered credit
  always_comb begin
    w_idle       = r_state == S_IDLE;
    w_coin_val   = coin_value(coin_t'(bus.coin));
    w_accept     = w_idle && !bus.cancel && w_coin_val != '0 &&
                   credit_sum_t'({1'b0, r_credit} + w_coin_val) <= credit_sum_t'(CREDIT_MAX);
    w_sum        = r_credit + (w_accept ? w_coin_val[CREDIT_W-1:0] : '0);
    w_sel_price  = price_of(bus.sel_id);
    w_vend_price = price_of(r_motor_id);
    w_sel        = w_idle && !bus.cancel && bus.sel_valid;
    w_sel_ok     = w_sel && !w_sold_out[bus.sel_id] && r_credit >= w_sel_price;
    w_refill     = w_idle && !bus.cancel && !bus.sel_valid && bus.refill;
    w_timeout    = r_state == S_VEND && !bus.motor_done && r_cnt == CW'(MOTOR_TIMEOUT - 1);
    w_jam_sum    = {1'b0, r_credit} + {1'b0, w_vend_price};
    w_stock_id   = w_idle ? bus.sel_id : r_motor_id;
  end
  vend_stock #(.STOCK_INIT(STOCK_INIT)) u_stock (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_refill),
    .i_dec      (w_sel_ok),
    .i_zero     (w_timeout),
    .i_id       (w_stock_id),
    .o_sold_out (w_sold_out)
  );
  // Sequencer FSM: credit bookkeeping, dispense handshake with timeout, payout, and registered pulses
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_cnt          <= '0;
      r_motor_id     <= '0;
      r_motor_req    <= 1'b0;
      r_payout_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_err_nostock  <= 1'b0;
      r_err_credit   <= 1'b0;
      r_jam          <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_coin_reject <= w_coin_val != '0 && !w_accept;
      r_err_nostock <= w_sel && w_sold_out[bus.sel_id];
      r_err_credit  <= w_sel && !w_sold_out[bus.sel_id] && r_credit < w_sel_price;
      r_jam         <= w_timeout;
      case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_credit <= w_sel_ok ? w_sum - w_sel_price : w_sum;
          if (bus.cancel && r_credit != '0) begin
            r_state        <= S_PAYOUT;
            r_payout_valid <= 1'b1;
            r_busy         <= 1'b1;
          end else if (w_sel_ok) begin
            r_state     <= S_VEND;
            r_motor_req <= 1'b1;
            r_motor_id  <= bus.sel_id;
            r_busy      <= 1'b1;
          end
        end
        S_VEND:
          if (bus.motor_done) begin
            r_motor_req    <= 1'b0;
            r_state        <= r_credit != '0 ? S_PAYOUT : S_IDLE;
            r_payout_valid <= r_credit != '0;
            r_busy         <= r_credit != '0;
          end else if (w_timeout) begin
            r_motor_req    <= 1'b0;
            r_credit       <= w_jam_sum[CREDIT_W] ? '1 : w_jam_sum[CREDIT_W-1:0];
            r_state        <= S_PAYOUT;
            r_payout_valid <= 1'b1;
          end else
            r_cnt <= r_cnt + 1'b1;
        S_PAYOUT:
          if (r_payout_valid && bus.payout_ready) begin
            r_credit <= r_credit - 1'b1;
            if (r_credit == credit_t'(1)) begin
              r_state        <= S_IDLE;
              r_payout_valid <= 1'b0;
              r_busy         <= 1'b0;
            end
          end
        default: begin
          r_state        <= S_IDLE;
          r_motor_req    <= 1'b0;
          r_payout_valid <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  assign bus.motor_req    = r_motor_req;
  assign bus.motor_id     = r_motor_id;
  assign bus.payout_valid = r_payout_valid;
  assign bus.coin_reject  = r_coin_reject;
  assign bus.err_nostock  = r_err_nostock;
  assign bus.err_credit   = r_err_credit;
  assign bus.jam          = r_jam;
  assign bus.credit       = r_credit;
  assign bus.sold_out     = w_sold_out;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed and random stimulus scored against a behavioural vending model
module tb_vend_sequencer;
  localparam int CMAX = 9, SINIT = 8, TMO = 15;
  localparam int M_IDLE = 0, M_VEND = 1, M_PAY = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  vend_if vif();
  vend_sequencer #(.PRICE0(3), .PRICE1(5), .PRICE2(7), .PRICE3(9), .CREDIT_MAX(CMAX),
                   .STOCK_INIT(SINIT), .MOTOR_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(vif.slave));
  always #5 clk = ~clk;
  int price [4] = '{3, 5, 7, 9};
  int m_mode, m_credit, m_mid, m_vc;
  int m_stock [4];
  logic [16:0] exp_q [$];
  int total = 0, passed = 0;
  bit run = 0;

  function automatic logic [16:0] model_out(input bit rej, input bit ens, input bit ec, input bit jm);
    logic [3:0] so;
    for (int i = 0; i < 4; i++) so[i] = m_stock[i] == 0;
    return {m_mode == M_VEND, 2'(m_mid), m_mode == M_PAY, rej, ens, ec, jm, 4'(m_credit), so, m_mode != M_IDLE};
  endfunction

  function automatic logic [16:0] dut_out();
    return {vif.motor_req, vif.motor_id, vif.payout_valid, vif.coin_reject, vif.err_nostock,
            vif.err_credit, vif.jam, vif.credit, vif.sold_out, vif.busy};
  endfunction

  function automatic string fmt(input logic [16:0] v);
    return $sformatf("mreq=%b mid=%0d pv=%b rej=%b nostk=%b ecr=%b jam=%b credit=%0d sold=%b busy=%b",
                     v[16], v[15:14], v[13], v[12], v[11], v[10], v[9], v[8:5], v[4:1], v[0]);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_credit = 0; m_mid = 0; m_vc = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = SINIT;
  endtask

  // One clock of the machine as the rules describe it; pushes the outputs expected after the edge
  task automatic model_step(input int c, input bit s, input int id, input bit cn, input bit rf, input bit dn, input bit rdy);
    int v, nc;
    bit rej, ens, ec, jm, take;
    v = c == 1 ? 1 : c == 2 ? 2 : 0;
    rej = 0; ens = 0; ec = 0; jm = 0;
    if (m_mode == M_IDLE) begin
      if (cn) begin
        rej = v > 0;
        if (m_credit > 0) m_mode = M_PAY;
      end else begin
        take = v > 0 && m_credit + v <= CMAX;
        rej = v > 0 && !take;
        nc = m_credit + (take ? v : 0);
        if (s) begin
          if (m_stock[id] == 0) ens = 1;
          else if (m_credit < price[id]) ec = 1;
          else begin
            nc -= price[id]; m_stock[id]--; m_mid = id; m_mode = M_VEND; m_vc = 0;
          end
        end else if (rf)
          for (int i = 0; i < 4; i++) m_stock[i] = SINIT;
        m_credit = nc;
      end
    end else begin
      rej = v > 0;
      if (m_mode == M_VEND) begin
        if (dn) m_mode = m_credit > 0 ? M_PAY : M_IDLE;
        else begin
          m_vc++;
          if (m_vc == TMO) begin
            jm = 1;
            m_credit = m_credit + price[m_mid] > 15 ? 15 : m_credit + price[m_mid];
            m_stock[m_mid] = 0;
            m_mode = M_PAY;
          end
        end
      end else if (rdy) begin
        m_credit--;
        if (m_credit == 0) m_mode = M_IDLE;
      end
    end
    exp_q.push_back(model_out(rej, ens, ec, jm));
  endtask

  task automatic step(input int c, input bit s, input int id, input bit cn, input bit rf, input bit dn, input bit rdy);
    vif.coin = 2'(c); vif.sel_valid = s; vif.sel_id = 2'(id); vif.cancel = cn;
    vif.refill = rf; vif.motor_done = dn; vif.payout_ready = rdy;
    model_step(c, s, id, cn, rf, dn, rdy);
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s got %0d expected %0d", name, got, want);
  endtask

  // Monitor: every cycle the DUT presents a full output set, which is scored against the oldest expectation
  always @(negedge clk)
    if (run) begin
      logic [16:0] e, g;
      total++;
      g = dut_out();
      if (exp_q.size() == 0) $display("FAIL scoreboard_empty t=%0t got %s expected a queued entry", $time, fmt(g));
      else begin
        e = exp_q.pop_front();
        if (g === e) passed++;
        else $display("FAIL outputs t=%0t got %s expected %s", $time, fmt(g), fmt(e));
      end
    end

  initial begin
    int c, n;
    vif.coin = 0; vif.sel_valid = 0; vif.sel_id = 0; vif.cancel = 0;
    vif.refill = 0; vif.motor_done = 0; vif.payout_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1;
    exp_q.push_back(model_out(0, 0, 0, 0));
    run = 1;
    // coins 2,1 then buy product 0, motor acks after two cycles
    step(2, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // credit 8, overflowing coin rejected, buy product 1, three coins change
    repeat (4) step(2, 0, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 0, 0, 0, 1);
    // credit 2 too low for product 2, then refund with hopper stalled three cycles
    step(2, 0, 0, 0, 0, 0, 0); step(0, 1, 2, 0, 0, 0, 0); step(1, 0, 0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);
    // credit 9 on product 3, motor never acks: jam, refund, sold out, then refill
    repeat (4) step(2, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 3, 0, 0, 0, 0);
    repeat (16) step(0, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 3, 0, 0, 0, 0); step(0, 0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
    // motor ack arriving on the very cycle the timeout would fire
    step(2, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0, 0);
    repeat (14) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    repeat (1500) begin
      c = $urandom_range(0, 7);
      step(c <= 4 ? 0 : c - 4, $urandom_range(0, 4) == 0, $urandom_range(0, 3), $urandom_range(0, 11) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end
    // drain to an idle, empty machine
    for (n = 0; n < 200 && !(m_mode == M_IDLE && m_credit == 0); n++) step(0, 0, 0, 1, 0, 1, 1);
    check("drain_bound", n < 200 ? 1 : 0, 1);
    // coin during vend rejected, then reset lands mid-payout
    step(0, 0, 0, 0, 1, 0, 0); step(2, 0, 0, 0, 0, 0, 0); step(2, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1 run = 0;
    check("payout_valid_before_reset", int'(vif.payout_valid), 1);
    check("credit_before_reset", int'(vif.credit), 2);
    rst = 0;
    #1;
    check("async_reset_credit", int'(vif.credit), 0);
    check("async_reset_payout_valid", int'(vif.payout_valid), 0);
    check("async_reset_motor_req", int'(vif.motor_req), 0);
    check("async_reset_busy", int'(vif.busy), 0);
    check("async_reset_sold_out", int'(vif.sold_out), 0);
    #20 rst = 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  PRICE0  3  price of product 0 in Rs
  PRICE1  5  price of product 1 in Rs
  PRICE2  7  price of product 2 in Rs
  PRICE3  9  price of product 3 in Rs
  CREDIT_MAX  9  max credit held, Rs (<=15)
  STOCK_INIT  8  per-product stock after reset/refill (<=15)
  MOTOR_TIMEOUT  15  cycles allowed for motor_done
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  coin  in  2  00 none, 01 1Rs, 10 2Rs, 11 invalid; one coin per cycle
  sel_valid  in  1  product selection strobe
  sel_id  in  2  product index 0..3
  cancel  in  1  refund request
  refill  in  1  restock all products
  motor_done  in  1  one-cycle ack from dispense motor
  payout_ready  in  1  hopper can eject one 1Rs coin this cycle
  motor_req  out  1  dispense request, held until ack/timeout
  motor_id  out  2  product being dispensed
  payout_valid  out  1  eject one 1Rs coin when payout_ready
  coin_reject  out  1  one-cycle pulse: current coin returned
  err_nostock  out  1  one-cycle pulse: selected product empty
  err_credit  out  1  one-cycle pulse: credit below price
  jam  out  1  one-cycle pulse: motor timeout
  credit  out  4  current credit, Rs
  sold_out  out  4  bit i high when stock i == 0
  busy  out  1  state != IDLE

Function
REQ-003 FSM states SHALL be IDLE, VEND, PAYOUT; all status/pulse outputs registered.
REQ-004 IDLE, coin 01/10: credit SHALL add 1/2 if credit+value <= CREDIT_MAX, else coin_reject pulses next cycle, credit unchanged; coin 11 SHALL be ignored, no reject.
REQ-005 IDLE priority SHALL be cancel > sel_valid; refill acts only when neither cancel nor sel_valid.
REQ-006 IDLE cancel: credit>0 -> PAYOUT; credit==0 -> stay IDLE; same-cycle coin rejected.
REQ-007 IDLE sel_valid: stock[sel_id]==0 -> err_nostock pulse; else credit<price -> err_credit pulse; both evaluated against registered credit (pre-coin); no state change on error.
REQ-008 IDLE accepted sel: credit_next = credit + accepted_coin - price; stock[sel_id] decrements; motor_id latched; -> VEND with motor_req high next cycle.
REQ-009 VEND: motor_req SHALL stay high until motor_done; timeout counter clears on entry, increments per cycle.
REQ-010 VEND motor_done: motor_req drops next cycle; credit>0 -> PAYOUT, else IDLE.
REQ-011 VEND timeout (counter reaches MOTOR_TIMEOUT, no motor_done): jam pulses, credit += price of motor_id (saturating at 15), stock[motor_id] forced to 0, motor_req drops, -> PAYOUT.
REQ-012 motor_done on the timeout cycle SHALL win (normal completion).
REQ-013 PAYOUT: payout_valid high while credit>0; each cycle payout_valid&&payout_ready decrements credit by 1; credit reaching 0 -> IDLE, payout_valid low that cycle.
REQ-014 VEND/PAYOUT: every coin 01/10 SHALL be rejected; sel_valid, cancel, refill ignored.
REQ-015 refill (IDLE): all stock counters SHALL load STOCK_INIT next cycle.
REQ-016 motor_done outside VEND SHALL be ignored.

Reset
REQ-017 rst low SHALL asynchronously force IDLE, credit 0, stock all STOCK_INIT, timeout counter 0, all outputs 0 (sold_out 0 when STOCK_INIT>0).
REQ-018 Reset mid-VEND/PAYOUT SHALL drop motor_req/payout_valid immediately; unreturned credit is lost.

Structure
REQ-019 Package vend_pkg SHALL hold state encoding, coin codes (NONE/ONE/TWO/INV), and credit/stock widths.
REQ-020 Stock counters SHALL be a sub-module vend_stock (4x4-bit, decrement, force-zero, load, sold_out).

Verification
REQ-021 Coins 10,01 then sel_id=0 -> credit 3->0, motor_req, motor_id=0; motor_done -> IDLE, stock0=7.
REQ-022 Credit 8, coin 10 -> coin_reject, credit 8; sel_id=1 -> VEND; motor_done -> PAYOUT, 3 payout_valid handshakes -> credit 0, IDLE.
REQ-023 Credit 2, sel_id=2 -> err_credit, credit 2; cancel with payout_ready held low 3 cycles then high -> credit 2,2,2,1,0.
REQ-024 sel_id=3 with credit 9, no motor_done for 15 cycles -> jam, sold_out[3]=1, 9 coins paid out; refill -> sold_out 0.
REQ-025 Coin 01 during VEND -> coin_reject; rst low in PAYOUT -> credit 0, payout_valid 0 asynchronously.
